// File: rtl/mac_accum_if.sv
// Handshake bundle between the driving side (multiply block plus sequencer) and
// the accumulation stage.
interface mac_accum_if #(
  parameter int INT_W = 32,
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
);
  logic             en;
  logic             start;
  logic [ACC_W-1:0] init;
  logic [CNT_W-1:0] len;
  logic [INT_W-1:0] prod;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             ovf;
  logic             busy;

  modport master (
    output en, start, init, len, prod, in_valid, out_ready,
    input  in_ready, out_data, out_valid, ovf, busy
  );

  modport slave (
    input  en, start, init, len, prod, in_valid, out_ready,
    output in_ready, out_data, out_valid, ovf, busy
  );
endinterface

// File: rtl/mac_accum_stage.sv
// Accumulation stage behind the combinational multiplier: sums a programmed
// number of products onto an initial value and presents the total on a handshake.
module mac_accum_stage #(
  parameter int INT_W  = 32,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 8,
  parameter int SIGNED = 0
) (
  input  logic      clk,
  input  logic      rst,
  mac_accum_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_accum;

  logic [ACC_W-1:0] w_ext;
  logic [ACC_W:0]   w_sum;
  logic             w_add_ovf;

  function automatic logic [ACC_W-1:0] ext_prod(input logic [INT_W-1:0] p);
    logic signed [INT_W-1:0] ps;
    ps = p;
    if (SIGNED != 0) ext_prod = ACC_W'(ps);
    else             ext_prod = ACC_W'(p);
  endfunction

  // Unsigned runs flag carry-out; signed runs flag a sign flip between like-signed operands.
  function automatic logic add_ovf(input logic [ACC_W-1:0] a,
                                   input logic [ACC_W-1:0] b,
                                   input logic [ACC_W:0]   s);
    if (SIGNED != 0) add_ovf = (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
    else             add_ovf = s[ACC_W];
  endfunction

  assign w_ext     = ext_prod(bus.prod);
  assign w_sum     = {1'b0, r_acc} + {1'b0, w_ext};
  assign w_add_ovf = add_ovf(r_acc, w_ext, w_sum);

  assign bus.in_ready  = r_accum & bus.en;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_acc;
  assign bus.ovf       = r_ovf;
  assign bus.busy      = r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_accum     <= 1'b0;
    end else if (bus.en) begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_acc  <= bus.init;
            r_cnt  <= bus.len;
            r_ovf  <= 1'b0;
            r_busy <= 1'b1;
            // An empty run skips straight to presenting the initial value.
            if (bus.len != '0) begin
              r_state <= S_ACCUM;
              r_accum <= 1'b1;
            end else begin
              r_state     <= S_HOLD;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_ACCUM: begin
          if (bus.in_valid) begin
            r_acc <= w_sum[ACC_W-1:0];
            r_cnt <= r_cnt - 1'b1;
            r_ovf <= r_ovf | w_add_ovf;
            if (r_cnt == CNT_W'(1)) begin
              r_state     <= S_HOLD;
              r_accum     <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_accum     <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accum_stage.sv
// Directed bench for mac_accum_stage: an unsigned and a signed instance share stimulus
// and are checked every cycle against an integer-arithmetic model of the run.
module tb_mac_accum_stage;
  localparam int INT_W = 32;
  localparam int ACC_W = 40;
  localparam int CNT_W = 8;
  localparam longint M  = longint'(1) << ACC_W;
  localparam longint HM = longint'(1) << (ACC_W - 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             en = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [ACC_W-1:0] init = '0;
  logic [CNT_W-1:0] len = '0;
  logic [INT_W-1:0] prod = '0;

  mac_accum_if #(.INT_W(INT_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) if_u ();
  mac_accum_if #(.INT_W(INT_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) if_s ();

  assign if_u.en = en;  assign if_u.start = start;  assign if_u.init = init;
  assign if_u.len = len;  assign if_u.prod = prod;  assign if_u.in_valid = in_valid;
  assign if_u.out_ready = out_ready;
  assign if_s.en = en;  assign if_s.start = start;  assign if_s.init = init;
  assign if_s.len = len;  assign if_s.prod = prod;  assign if_s.in_valid = in_valid;
  assign if_s.out_ready = out_ready;

  mac_accum_stage #(.INT_W(INT_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .bus(if_u));
  mac_accum_stage #(.INT_W(INT_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .bus(if_s));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = waiting for start, 1 = collecting products, 2 = presenting result.
  int     m_phase = 0;
  int     m_left  = 0;
  longint m_acc_u = 0, m_acc_s = 0;
  bit     m_ovf_u = 0, m_ovf_s = 0;
  longint m_last_u = -1, m_last_s = -1;

  function automatic longint as_signed(input longint v, input int w);
    longint half;
    half = longint'(1) << (w - 1);
    return (v >= half) ? v - (longint'(1) << w) : v;
  endfunction

  always @(posedge clk) begin
    longint ex;
    if (rst) begin
      m_phase = 0; m_left = 0; m_acc_u = 0; m_acc_s = 0; m_ovf_u = 0; m_ovf_s = 0;
    end else if (en) begin
      case (m_phase)
        0: if (start) begin
          m_acc_u = longint'(init); m_acc_s = longint'(init);
          m_ovf_u = 0; m_ovf_s = 0; m_left = int'(len);
          m_phase = (len != 0) ? 1 : 2;
        end
        1: if (in_valid) begin
          ex = m_acc_u + longint'(prod);
          if (ex >= M) m_ovf_u = 1;
          m_acc_u = ex % M;
          ex = as_signed(m_acc_s, ACC_W) + as_signed(longint'(prod), INT_W);
          if (ex > HM - 1 || ex < -HM) m_ovf_s = 1;
          m_acc_s = ((ex % M) + M) % M;
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: if (out_ready) begin
          m_last_u = m_acc_u; m_last_s = m_acc_s; m_phase = 0;
        end
      endcase
    end
  end

  longint last_u = -1, last_s = -1;
  bit     lovf_u = 0, lovf_s = 0;

  always @(negedge clk) begin
    chk("in_ready_u",  if_u.in_ready,  (m_phase == 1) && en);
    chk("in_ready_s",  if_s.in_ready,  (m_phase == 1) && en);
    chk("out_valid_u", if_u.out_valid, m_phase == 2);
    chk("out_valid_s", if_s.out_valid, m_phase == 2);
    chk("busy_u",      if_u.busy,      m_phase != 0);
    chk("busy_s",      if_s.busy,      m_phase != 0);
    chk("ovf_u",       if_u.ovf,       m_ovf_u);
    chk("ovf_s",       if_s.ovf,       m_ovf_s);
    if (m_phase == 2) begin
      chk("out_data_u", if_u.out_data, m_acc_u);
      chk("out_data_s", if_s.out_data, m_acc_s);
    end
    if (if_u.out_valid && out_ready && en && !rst) begin
      last_u = longint'(if_u.out_data); lovf_u = if_u.ovf;
    end
    if (if_s.out_valid && out_ready && en && !rst) begin
      last_s = longint'(if_s.out_data); lovf_s = if_s.ovf;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with start and in_valid both asserted
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; prod = 32'd99; init = 40'd7; len = 8'd2;
    tick(); tick();
    chk("rst_out_valid", if_u.out_valid, 0);
    chk("rst_in_ready",  if_u.in_ready, 0);
    chk("rst_busy",      if_u.busy, 0);
    chk("rst_ovf",       if_u.ovf, 0);
    chk("rst_out_data",  if_u.out_data, 0);

    // Basic run: 5 + 10 + 20 + 30
    rst = 1'b0; start = 1'b1; in_valid = 1'b0; init = 40'd5; len = 8'd3; out_ready = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b1;
    prod = 32'd10; tick();
    prod = 32'd20; tick();
    prod = 32'd30; tick();
    in_valid = 1'b0;
    chk("basic_vis_valid", if_u.out_valid, 1);
    chk("basic_vis_data",  if_u.out_data, 65);
    tick();
    chk("basic_sum",   last_u, 65);
    chk("basic_model", m_last_u, 65);
    chk("basic_ovf",   lovf_u, 0);
    chk("basic_idle",  if_u.out_valid, 0);

    // Back-pressure: gapped input, mid-run start ignored, output held
    out_ready = 1'b0; start = 1'b1; init = 40'd0; len = 8'd4;
    tick();
    for (int i = 0; i < 8; i++) begin
      in_valid = (i % 2 == 0);
      prod     = 32'(100 * (i / 2 + 1));
      start    = (i == 3);
      init     = 40'd777;
      tick();
    end
    start = 1'b0; in_valid = 1'b1; prod = 32'd55;
    for (int i = 0; i < 5; i++) tick();
    chk("bp_hold_data",  if_u.out_data, 1000);
    chk("bp_hold_ready", if_u.in_ready, 0);
    chk("bp_model",      m_acc_u, 1000);
    start = 1'b1; init = 40'd777; len = 8'd2; out_ready = 1'b1; in_valid = 1'b0;
    tick();
    start = 1'b0;
    chk("bp_sum",          last_u, 1000);
    chk("bp_start_dropped", if_u.busy, 0);

    // len = 0 presents init the cycle after start
    start = 1'b1; init = 40'h12345; len = 8'd0; in_valid = 1'b1; prod = 32'd999; out_ready = 1'b0;
    tick();
    start = 1'b0;
    chk("len0_valid", if_u.out_valid, 1);
    chk("len0_data",  if_u.out_data, 40'h12345);
    out_ready = 1'b1; in_valid = 1'b0;
    tick();
    chk("len0_sum", last_u, 40'h12345);

    // Unsigned overflow: all-ones + 1
    start = 1'b1; init = '1; len = 8'd1;
    tick();
    start = 1'b0; in_valid = 1'b1; prod = 32'd1;
    tick();
    in_valid = 1'b0;
    chk("uovf_data", if_u.out_data, 0);
    chk("uovf_flag", if_u.ovf, 1);
    chk("uovf_s_flag", if_s.ovf, 0);
    tick();

    // Signed overflow: max positive + 1; this run also clears the unsigned flag
    start = 1'b1; init = 40'h7F_FFFF_FFFF; len = 8'd1;
    tick();
    start = 1'b0; in_valid = 1'b1; prod = 32'd1;
    tick();
    in_valid = 1'b0;
    chk("sovf_flag",    if_s.ovf, 1);
    chk("sovf_data",    if_s.out_data, 40'h80_0000_0000);
    chk("sovf_u_clear", if_u.ovf, 0);
    tick();
    chk("sovf_model", m_last_s, 40'h80_0000_0000);

    // Next run clears the signed flag; negative product sign-extends
    start = 1'b1; init = 40'd10; len = 8'd1;
    tick();
    start = 1'b0; in_valid = 1'b1; prod = 32'hFFFF_FFFD;
    tick();
    in_valid = 1'b0;
    chk("s_clear",   if_s.ovf, 0);
    chk("s_negsum",  if_s.out_data, 40'd7);
    chk("u_bigsum",  if_u.out_data, 40'h1_0000_0007);
    tick();

    // Enable gating in ACCUM and HOLD
    start = 1'b1; init = 40'd0; len = 8'd3; out_ready = 1'b0;
    tick();
    start = 1'b0; in_valid = 1'b1; prod = 32'd7;
    tick();
    en = 1'b0;
    tick(); tick(); tick();
    chk("en0_ready", if_u.in_ready, 0);
    chk("en0_data",  if_u.out_data, 7);
    en = 1'b1;
    tick(); tick();
    in_valid = 1'b0; en = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();
    chk("en0_hold_valid", if_u.out_valid, 1);
    chk("en0_hold_data",  if_u.out_data, 21);
    en = 1'b1;
    tick();
    chk("en_sum", last_u, 21);

    // Reset mid-run discards it; a fresh run then sums correctly
    start = 1'b1; init = 40'd0; len = 8'd3; out_ready = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b1; prod = 32'd9;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("midrst_valid", if_u.out_valid, 0);
    chk("midrst_busy",  if_u.busy, 0);
    chk("midrst_data",  if_u.out_data, 0);
    start = 1'b1; init = 40'd1; len = 8'd2;
    tick();
    start = 1'b0; in_valid = 1'b1;
    prod = 32'd2; tick();
    prod = 32'd3; tick();
    in_valid = 1'b0;
    tick();
    chk("fresh_sum",   last_u, 6);
    chk("fresh_sum_s", last_s, 6);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
